// File: rtl/game_display_ctrl.sv
// ============================================================================
// Module      : game_display_ctrl
// Description : Countdown game round controller. Drives timer, current score
//               and high score for a 7-segment display. Optional OVER-state
//               display blinking is compiled in with `define OVER_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_display_ctrl #(
  parameter int CLK_HZ       = 50000000,
  parameter int GAME_SECONDS = 60,
  parameter int MAX_SCORE    = 99
) (
  input  logic        CLK50MHZ,
  input  logic        reset,
  input  logic        start,
  input  logic        hit,
  input  logic        stop,
  output logic [31:0] timer,
  output logic [31:0] currentScore,
  output logic [31:0] highScore,
  output logic        running,
  output logic        game_over,
  output logic        blank
);

  localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_OVER = 2'd2;

  localparam logic [TICK_W-1:0] c_TICK_MAX  = TICK_W'(CLK_HZ - 1);
  localparam logic [6:0]        c_GAME_SECS = 7'(GAME_SECONDS);
  localparam logic [6:0]        c_MAX_SCORE = 7'(MAX_SCORE);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [TICK_W-1:0] r_tick;
  logic [6:0]        r_timer;
  logic [6:0]        r_score;
  logic [6:0]        r_high;
  logic [6:0]        w_score_nxt;
  logic              w_wrap;
  logic              w_timeout;
  logic              w_score_inc;

  assign w_wrap      = (r_tick == c_TICK_MAX);
  assign w_timeout   = (r_state == c_RUN) && w_wrap && (r_timer == 7'd1);
  assign w_score_inc = (r_state == c_RUN) && hit && (r_score < c_MAX_SCORE);
  assign w_score_nxt = r_score + 7'(w_score_inc);

  // State register
  always_ff @(posedge CLK50MHZ) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: start beats stop, stop beats timeout
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (start) w_state_nxt = c_RUN;
      end
      c_RUN: begin
        if (start)          w_state_nxt = c_RUN;
        else if (stop)      w_state_nxt = c_OVER;
        else if (w_timeout) w_state_nxt = c_OVER;
      end
      c_OVER: begin
        if (start) w_state_nxt = c_RUN;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Round datapath; stop freezes the timer on the cycle it aborts the round
  always_ff @(posedge CLK50MHZ) begin
    if (reset) begin
      r_tick  <= '0;
      r_timer <= '0;
      r_score <= '0;
      r_high  <= '0;
    end else if (start) begin
      r_tick  <= '0;
      r_timer <= c_GAME_SECS;
      r_score <= '0;
    end else if (r_state == c_RUN) begin
      r_score <= w_score_nxt;
      if (!stop) begin
        r_tick <= w_wrap ? '0 : r_tick + TICK_W'(1);
        if (w_wrap) r_timer <= r_timer - 7'd1;
      end
      if (w_state_nxt == c_OVER && w_score_nxt > r_high) begin
        r_high <= w_score_nxt;
      end
    end
  end

  // Output decode
  always_comb begin
    running      = (r_state == c_RUN);
    game_over    = (r_state == c_OVER);
    timer        = {25'd0, r_timer};
    currentScore = {25'd0, r_score};
    highScore    = {25'd0, r_high};
  end

`ifdef OVER_BLINK_EN
  localparam int BLINK_DIV = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] c_BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blank;

  // Counting only while staying in OVER makes entry and exit both clear blank
  always_ff @(posedge CLK50MHZ) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_blank     <= 1'b0;
    end else if (r_state == c_OVER && w_state_nxt == c_OVER) begin
      if (r_blink_cnt == c_BLINK_MAX) begin
        r_blink_cnt <= '0;
        r_blank     <= ~r_blank;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end else begin
      r_blink_cnt <= '0;
      r_blank     <= 1'b0;
    end
  end

  assign blank = r_blank;
`else
  assign blank = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_game_display_ctrl.sv
// ============================================================================
// Module      : tb_game_display_ctrl
// Description : Table-driven, scoreboard-checked bench for game_display_ctrl
//               with CLK_HZ=4, GAME_SECONDS=3, MAX_SCORE=5.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_display_ctrl;

  logic        CLK50MHZ = 1'b0;
  logic        reset = 1'b0, start = 1'b0, hit = 1'b0, stop = 1'b0;
  logic [31:0] timer, currentScore, highScore;
  logic        running, game_over, blank;

  int checks   = 0;
  int failures = 0;

  game_display_ctrl #(.CLK_HZ(4), .GAME_SECONDS(3), .MAX_SCORE(5)) dut (
    .CLK50MHZ    (CLK50MHZ),
    .reset       (reset),
    .start       (start),
    .hit         (hit),
    .stop        (stop),
    .timer       (timer),
    .currentScore(currentScore),
    .highScore   (highScore),
    .running     (running),
    .game_over   (game_over),
    .blank       (blank)
  );

  always #5 CLK50MHZ = ~CLK50MHZ;

  typedef struct {
    logic rst, st, ht, sp;
    int   idle;
    int   t, s, h;
    logic run, ovr;
  } vec_t;

  typedef struct {
    int   row;
    int   t, s, h;
    logic run, ovr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input int row, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0d expected=%0d", name, row, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK50MHZ);
    #1;
  endtask

  task automatic add(input logic r, input logic s, input logic h, input logic p, input int idle,
                     input int t, input int sc, input int hs, input logic rn, input logic ov);
    vec_t v;
    v.rst = r; v.st = s; v.ht = h; v.sp = p; v.idle = idle;
    v.t = t; v.s = sc; v.h = hs; v.run = rn; v.ovr = ov;
    vecs.push_back(v);
  endtask

  initial begin
    exp_t e;
    int   n;
    // rst st ht sp idle   t  s  h run over
    add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // reset
    add(0, 0, 1, 0, 0,   0, 0, 0, 0, 0);  // hit in IDLE ignored
    add(0, 0, 1, 0, 2,   0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0,   3, 0, 0, 1, 0);  // start
    add(0, 0, 0, 0, 2,   3, 0, 0, 1, 0);  // 3 cycles in: no tick yet
    add(0, 0, 0, 0, 0,   2, 0, 0, 1, 0);  // cycle 4
    add(0, 0, 0, 0, 3,   1, 0, 0, 1, 0);  // cycle 8
    add(0, 0, 0, 0, 2,   1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 1);  // cycle 12: timeout
    add(0, 0, 0, 0, 3,   0, 0, 0, 0, 1);  // OVER holds
    add(0, 0, 1, 0, 0,   0, 0, 0, 0, 1);  // hit in OVER ignored
    add(0, 1, 0, 0, 0,   3, 0, 0, 1, 0);  // new round
    add(0, 0, 1, 0, 0,   3, 1, 0, 1, 0);
    add(0, 0, 1, 0, 0,   3, 2, 0, 1, 0);
    add(0, 0, 1, 0, 0,   3, 3, 0, 1, 0);
    add(0, 0, 1, 0, 0,   2, 4, 0, 1, 0);
    add(0, 0, 1, 0, 0,   2, 5, 0, 1, 0);
    add(0, 0, 1, 0, 0,   2, 5, 0, 1, 0);  // saturated
    add(0, 0, 1, 0, 0,   2, 5, 0, 1, 0);
    add(0, 0, 0, 0, 4,   0, 5, 5, 0, 1);  // timeout, high=5
    add(0, 1, 0, 0, 0,   3, 0, 5, 1, 0);
    add(0, 0, 1, 0, 0,   3, 1, 5, 1, 0);
    add(0, 0, 1, 0, 0,   3, 2, 5, 1, 0);
    add(0, 0, 0, 1, 0,   3, 2, 5, 0, 1);  // stop: timer frozen
    add(0, 0, 0, 0, 5,   3, 2, 5, 0, 1);
    add(0, 0, 0, 1, 0,   3, 2, 5, 0, 1);  // stop in OVER ignored
    add(0, 1, 0, 0, 0,   3, 0, 5, 1, 0);
    add(0, 0, 1, 0, 0,   3, 1, 5, 1, 0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // reset mid-round
    add(0, 1, 0, 0, 10,  1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0,   1, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0,   0, 1, 1, 0, 1);  // hit on final tick counts
    add(0, 1, 0, 0, 0,   3, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0,   3, 1, 1, 1, 0);
    add(0, 0, 1, 0, 3,   2, 2, 1, 1, 0);
    add(0, 1, 0, 0, 0,   3, 0, 1, 1, 0);  // restart in RUN, no high update
    add(0, 1, 1, 1, 0,   3, 0, 1, 1, 0);  // start beats stop and hit
    add(0, 0, 1, 0, 0,   3, 1, 1, 1, 0);
    add(0, 0, 1, 0, 0,   3, 2, 1, 1, 0);
    add(0, 0, 1, 1, 0,   3, 3, 3, 0, 1);  // stop with hit: hit included

    @(negedge CLK50MHZ);
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; start = vecs[i].st; hit = vecs[i].ht; stop = vecs[i].sp;
      e.row = i; e.t = vecs[i].t; e.s = vecs[i].s; e.h = vecs[i].h;
      e.run = vecs[i].run; e.ovr = vecs[i].ovr;
      sb.push_back(e);
      step();
      reset = 0; start = 0; hit = 0; stop = 0;
      for (int k = 0; k < vecs[i].idle; k++) step();
      e = sb.pop_front();
      chk("timer", e.row, timer, e.t);
      chk("currentScore", e.row, currentScore, e.s);
      chk("highScore", e.row, highScore, e.h);
      chk("running", e.row, running, e.run);
      chk("game_over", e.row, game_over, e.ovr);
`ifdef OVER_BLINK_EN
      if (!e.ovr) chk("blank", e.row, blank, 0);
`else
      chk("blank", e.row, blank, 0);
`endif
    end

    // Exact first-tick latency and round length, bounded waits
    start = 1; step(); start = 0;
    n = 0;
    while (timer == 32'd3 && n < 20) begin step(); n++; end
    chk("first_tick_cycles", 100, n, 4);
    chk("first_tick_timer", 100, timer, 2);
    while (!game_over && n < 40) begin step(); n++; end
    chk("round_cycles", 101, n, 12);
    chk("round_timer", 101, timer, 0);

`ifdef OVER_BLINK_EN
    chk("blank_entry", 102, blank, 0);
    step(); chk("blank_t1", 103, blank, 1);
    step(); chk("blank_t2", 104, blank, 0);
    step(); chk("blank_t3", 105, blank, 1);
    start = 1; step(); start = 0;
    chk("blank_run", 106, blank, 0);
`else
    for (int k = 0; k < 4; k++) begin
      chk("blank_over", 102 + k, blank, 0);
      step();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
